// File: rtl/bbox_crop_scaler.sv
// rtl/bbox_crop_scaler.sv - nearest-neighbour crop of a BMP bounding box into an OUT_DIM x OUT_DIM grey tile
// Optional build macro BBOX_CROP_INVERT_EN: emit 255 - grey (white-on-black) instead of grey.
module bbox_crop_scaler #(
    parameter int WIDTH   = 100,
    parameter int HEIGHT  = 100,
    parameter int OUT_DIM = 28,
    parameter int BG_GREY = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] x_min,
    input  logic [10:0] x_max,
    input  logic [10:0] y_min,
    input  logic [10:0] y_max,
    output logic [31:0] addr,
    input  logic [15:0] rddata,
    output logic [7:0]  pix_data,
    output logic [5:0]  pix_x,
    output logic [5:0]  pix_y,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_RD_R,
        S_CAP_R,
        S_RD_G,
        S_CAP_G,
        S_RD_B,
        S_CAP_B,
        S_EMIT,
        S_FINISHED
    } state_t;

    localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);
    localparam logic [5:0]  O_LAST = 6'(OUT_DIM - 1);
    localparam logic [7:0]  BG     = 8'(BG_GREY);
`ifdef BBOX_CROP_INVERT_EN
    localparam logic [7:0]  BG_OUT = 8'd255 - BG;
`else
    localparam logic [7:0]  BG_OUT = BG;
`endif

    state_t      state, next_state;

    logic [10:0] bx0, by0, bw, bh;
    logic        box_empty;
    logic [5:0]  ox, oy;
    logic [7:0]  r_q, g_q;
    logic [31:0] addr_hold;

    logic [10:0] cx_min, cx_max, cy_min, cy_max;
    logic        in_empty;
    logic        at_last;
    logic [31:0] ox_bw, oy_bh, sx, sy, base;
    logic [9:0]  grey_sum;
    logic [7:0]  grey, grey_out;
    logic        unused_rd_hi;

    assign unused_rd_hi = ^rddata[15:8];

    // Emptiness is judged on the raw box: the box stage's "no foreground" values have min > max.
    always_comb begin
        cx_min   = (x_min >= 11'(WIDTH))  ? X_LAST : x_min;
        cx_max   = (x_max >= 11'(WIDTH))  ? X_LAST : x_max;
        cy_min   = (y_min >= 11'(HEIGHT)) ? Y_LAST : y_min;
        cy_max   = (y_max >= 11'(HEIGHT)) ? Y_LAST : y_max;
        in_empty = (x_min > x_max) || (y_min > y_max);
    end

    // Since ox < OUT_DIM the scaled offset is always < bw, so reads stay inside the box.
    always_comb begin
        ox_bw = 32'(ox) * 32'(bw);
        oy_bh = 32'(oy) * 32'(bh);
        sx    = 32'(bx0) + ox_bw / 32'(OUT_DIM);
        sy    = 32'(by0) + oy_bh / 32'(OUT_DIM);
        base  = (32'(HEIGHT - 1) - sy) * 32'(WIDTH * 3) + sx * 32'd3;
    end

    always_comb begin
        addr = addr_hold;
        case (state)
            S_RD_R:  addr = base;
            S_RD_G:  addr = base + 32'd1;
            S_RD_B:  addr = base + 32'd2;
            default: addr = addr_hold;
        endcase
    end

    always_comb begin
        grey_sum = {2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, rddata[7:0]};
        grey     = grey_sum[9:2];
`ifdef BBOX_CROP_INVERT_EN
        grey_out = 8'd255 - grey;
`else
        grey_out = grey;
`endif
    end

    assign at_last   = (ox == O_LAST) && (oy == O_LAST);
    assign pix_x     = ox;
    assign pix_y     = oy;
    assign pix_last  = pix_valid && at_last;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = S_SETUP;
            S_SETUP:    next_state = in_empty ? S_EMIT : S_RD_R;
            S_RD_R:     next_state = S_CAP_R;
            S_CAP_R:    next_state = S_RD_G;
            S_RD_G:     next_state = S_CAP_G;
            S_CAP_G:    next_state = S_RD_B;
            S_RD_B:     next_state = S_CAP_B;
            S_CAP_B:    next_state = S_EMIT;
            S_EMIT: begin
                if (pix_ready) begin
                    if (at_last)        next_state = S_FINISHED;
                    else if (box_empty) next_state = S_EMIT;
                    else                next_state = S_RD_R;
                end
            end
            S_FINISHED: if (start) next_state = S_SETUP;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            pix_valid <= (next_state == S_EMIT);
            busy      <= (next_state != S_IDLE) && (next_state != S_FINISHED);
            done      <= (next_state == S_FINISHED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx0       <= '0;
            by0       <= '0;
            bw        <= '0;
            bh        <= '0;
            box_empty <= 1'b0;
            ox        <= '0;
            oy        <= '0;
            r_q       <= '0;
            g_q       <= '0;
            pix_data  <= '0;
            addr_hold <= '0;
        end else begin
            if ((state == S_RD_R) || (state == S_RD_G) || (state == S_RD_B))
                addr_hold <= addr;
            case (state)
                S_SETUP: begin
                    bx0       <= cx_min;
                    by0       <= cy_min;
                    bw        <= cx_max - cx_min + 11'd1;
                    bh        <= cy_max - cy_min + 11'd1;
                    box_empty <= in_empty;
                    ox        <= '0;
                    oy        <= '0;
                    if (in_empty)
                        pix_data <= BG_OUT;
                end
                S_CAP_R: r_q      <= rddata[7:0];
                S_CAP_G: g_q      <= rddata[7:0];
                S_CAP_B: pix_data <= grey_out;
                S_EMIT: begin
                    if (pix_ready) begin
                        if (ox == O_LAST) begin
                            ox <= '0;
                            oy <= (oy == O_LAST) ? 6'd0 : oy + 6'd1;
                        end else begin
                            ox <= ox + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_crop_scaler.sv
// tb/tb_bbox_crop_scaler.sv - table-driven bench for bbox_crop_scaler with a frame-buffer model
module tb_bbox_crop_scaler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] x_min, x_max, y_min, y_max;
    logic [31:0] addr;
    logic [15:0] rddata = 16'h0;
    logic [7:0]  pix_data;
    logic [5:0]  pix_x, pix_y;
    logic        pix_valid, pix_ready, pix_last, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    bit oob      = 0;

    logic [7:0] mem [0:29999];

    typedef struct {
        int xmn, xmx, ymn, ymx;
        int x0, y0, bw, bh;
        bit empty;
        int first_addr;
    } vec_t;

    vec_t vecs [5];

`ifdef BBOX_CROP_INVERT_EN
    localparam logic [7:0] BG_EXP = 8'd0;
`else
    localparam logic [7:0] BG_EXP = 8'd255;
`endif

    bbox_crop_scaler dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .addr(addr), .rddata(rddata),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        rddata <= (addr < 32'd30000) ? {8'hA5, mem[addr]} : 16'hDEAD;

    always @(negedge clk)
        if (rst_n && addr > 32'd29999) oob <= 1'b1;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 13) ^ (a >> 5));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_tile(input vec_t v, input bit bp);
        int n, idx, first_v, done_n, stall, ox, oy, sx, sy, a, sum;
        logic [7:0]  ed;
        logic [52:0] snap;
        logic [31:0] addr0;
        bit prev_stall, moved;
        @(negedge clk);
        x_min = 11'(v.xmn); x_max = 11'(v.xmx);
        y_min = 11'(v.ymn); y_max = 11'(v.ymx);
        start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy_done", {busy, done}, 2'b10);
        addr0 = addr; n = 0; idx = 0; first_v = -1; done_n = -1; stall = 0;
        prev_stall = 0; moved = 0; oob = 0; snap = '0;
        while (done_n < 0 && n < 20000) begin
            if (prev_stall) begin
                check("stall_hold", {pix_valid, pix_x, pix_y, pix_data, pix_last, addr}, {1'b1, snap});
                prev_stall = 0;
            end
            if (addr !== addr0) moved = 1;
            if (n == 1 && !v.empty) check("first_addr", addr, 64'(v.first_addr));
            if (n == 1) begin
                x_min = 11'($urandom); x_max = 11'($urandom);
                y_min = 11'($urandom); y_max = 11'($urandom);
            end
            if (n == 100) start = 1'b1;
            if (n == 101) start = 1'b0;
            if (pix_valid) begin
                if (first_v < 0) first_v = n;
                if (bp && idx == 3 && stall < 5) begin
                    pix_ready = 1'b0;
                    stall++;
                end else begin
                    pix_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (pix_ready) begin
                    ox = idx % 28; oy = idx / 28;
                    if (v.empty) begin
                        ed = BG_EXP;
                    end else begin
                        sx = v.x0 + (ox * v.bw) / 28;
                        sy = v.y0 + (oy * v.bh) / 28;
                        a = (99 - sy) * 300 + sx * 3;
                        sum = int'(pat(a)) + 2 * int'(pat(a + 1)) + int'(pat(a + 2));
                        ed = 8'(sum >> 2);
`ifdef BBOX_CROP_INVERT_EN
                        ed = 8'd255 - ed;
`endif
                    end
                    check("pixel", {pix_x, pix_y, pix_data, pix_last},
                          {6'(ox), 6'(oy), ed, (idx == 783)});
                    idx++;
                end else begin
                    snap = {pix_x, pix_y, pix_data, pix_last, addr};
                    prev_stall = 1;
                end
            end else begin
                pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            n++;
            if (done) done_n = n;
        end
        check("tile_done", done_n >= 0, 1);
        check("pix_count", idx, 784);
        check("first_valid", first_v, v.empty ? 1 : 7);
        if (!bp) check("done_cycles", done_n, v.empty ? 785 : 5489);
        if (v.empty) check("empty_no_reads", moved, 0);
        check("addr_range", oob, 0);
        check("finished_flags", {busy, pix_valid}, 2'b00);
    endtask

    initial begin
        vecs[0] = '{10, 37, 20, 47, 10, 20, 28, 28, 1'b0, 23730};
        vecs[1] = '{0, 13, 0, 13, 0, 0, 14, 14, 1'b0, 29700};
        vecs[2] = '{99, 0, 0, 99, 0, 0, 0, 0, 1'b1, 0};
        vecs[3] = '{90, 120, 90, 150, 90, 90, 10, 10, 1'b0, 2970};
        vecs[4] = '{0, 99, 0, 99, 0, 0, 100, 100, 1'b0, 29700};
        for (int i = 0; i < 30000; i++) mem[i] = pat(i);

        rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
        x_min = '0; x_max = '0; y_min = '0; y_max = '0;
        repeat (3) @(negedge clk);
        check("reset_flags", {busy, done, pix_valid, pix_last}, 4'b0000);
        check("reset_addr", addr, 0);
        check("reset_pix", {pix_data, pix_x, pix_y}, 20'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_tile(vecs[i], 1'b0);

        run_tile(vecs[0], 1'b1);

        // Asynchronous reset in the middle of RD_G, away from any clock edge
        @(negedge clk);
        x_min = 11'd10; x_max = 11'd37; y_min = 11'd20; y_max = 11'd47;
        start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_flags", {busy, done, pix_valid}, 3'b000);
        check("abort_addr", addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_tile(vecs[1], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
